// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the RV32I datapath.
// The master side is the controller; the slave side is the datapath and
// the unified memory port that consume its select lines.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        mem_ready;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic [2:0]  imm_type;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        retire;
    logic [2:0]  state;
    logic        illegal;

    modport master (
        input  instr, mem_ready, branch_taken,
        output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src_b,
               alu_op, imm_type, reg_we, wb_sel, retire, state, illegal
    );

    modport slave (
        output instr, mem_ready, branch_taken,
        input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_src_b,
               alu_op, imm_type, reg_we, wb_sel, retire, state, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing controller for the RV32I core.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives
// the datapath select lines from the current state and the latched opcode.
// Optional feature: define MC_CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes
// into a HALT state; otherwise they retire as a NOP in DECODE.
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        ,
        HALT   = 3'd5
`endif
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t     state_q;
    state_t     state_d;
    logic [6:0] opcode;
    logic       supported;
    logic [2:0] immDecoded;
    logic       unusedInstrBits;

    assign opcode = bus.instr[6:0];

    // Only the opcode steers sequencing; the remaining fields feed the datapath.
    assign unusedInstrBits = ^bus.instr[31:7];

    // Opcode classification and the immediate format each supported opcode uses.
    always_comb begin
        supported  = 1'b1;
        immDecoded = 3'd4;
        unique case (opcode)
            OPC_OPIMM, OPC_LOAD, OPC_JALR: immDecoded = 3'd0;
            OPC_STORE:                     immDecoded = 3'd1;
            OPC_BRANCH:                    immDecoded = 3'd2;
            OPC_JAL:                       immDecoded = 3'd3;
            OPC_OP:                        immDecoded = 3'd4;
            default:                       supported  = 1'b0;
        endcase
    end

    // State register; reset always returns the sequencer to FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore outputs; reset forces every output low.
    always_comb begin
        state_d       = state_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.addr_sel  = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_sel    = 2'd0;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = 2'd0;
        bus.imm_type  = 3'd4;
        bus.reg_we    = 1'b0;
        bus.wb_sel    = 2'd0;
        bus.retire    = 1'b0;
        bus.illegal   = 1'b0;

        unique case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_we = 1'b1;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                bus.imm_type = immDecoded;
                if (supported) begin
                    state_d = EXEC;
                end else begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    state_d = HALT;
`else
                    bus.pc_we  = 1'b1;
                    bus.retire = 1'b1;
                    state_d    = FETCH;
`endif
                end
            end
            EXEC: begin
                bus.imm_type = immDecoded;
                unique case (opcode)
                    OPC_OP, OPC_OPIMM: begin
                        bus.alu_op    = 2'd1;
                        bus.alu_src_b = (opcode == OPC_OPIMM);
                        state_d       = WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        bus.alu_src_b = 1'b1;
                        state_d       = MEM;
                    end
                    OPC_BRANCH: begin
                        bus.alu_op = 2'd2;
                        bus.pc_we  = 1'b1;
                        bus.pc_sel = bus.branch_taken ? 2'd1 : 2'd0;
                        bus.retire = 1'b1;
                        state_d    = FETCH;
                    end
                    OPC_JAL, OPC_JALR: state_d = WB;
                    default:           state_d = FETCH;
                endcase
            end
            MEM: begin
                bus.imm_type = immDecoded;
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (opcode == OPC_STORE);
                if (bus.mem_ready) begin
                    if (opcode == OPC_STORE) begin
                        bus.pc_we  = 1'b1;
                        bus.retire = 1'b1;
                        state_d    = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                bus.imm_type = immDecoded;
                bus.reg_we   = 1'b1;
                bus.pc_we    = 1'b1;
                bus.retire   = 1'b1;
                state_d      = FETCH;
                unique case (opcode)
                    OPC_LOAD: bus.wb_sel = 2'd1;
                    OPC_JAL: begin
                        bus.wb_sel = 2'd2;
                        bus.pc_sel = 2'd1;
                    end
                    OPC_JALR: begin
                        bus.wb_sel = 2'd2;
                        bus.pc_sel = 2'd2;
                    end
                    default:  bus.wb_sel = 2'd0;
                endcase
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            HALT: begin
                bus.imm_type = 3'd0;
                bus.illegal  = 1'b1;
                state_d      = HALT;
            end
`endif
            default: begin
                bus.imm_type = 3'd0;
                state_d      = FETCH;
            end
        endcase

        if (rst) begin
            bus.mem_req   = 1'b0;
            bus.mem_we    = 1'b0;
            bus.addr_sel  = 1'b0;
            bus.ir_we     = 1'b0;
            bus.pc_we     = 1'b0;
            bus.pc_sel    = 2'd0;
            bus.alu_src_b = 1'b0;
            bus.alu_op    = 2'd0;
            bus.imm_type  = 3'd0;
            bus.reg_we    = 1'b0;
            bus.wb_sel    = 2'd0;
            bus.retire    = 1'b0;
            bus.illegal   = 1'b0;
        end
    end

    // Debug view of the sequencer position, held at zero during reset.
    always_comb begin
        bus.state = rst ? 3'd0 : state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks representative RV32I
// instructions through the sequencer and checks every control output each cycle.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] state;
        logic       memReq;
        logic       memWe;
        logic       addrSel;
        logic       irWe;
        logic       pcWe;
        logic [1:0] pcSel;
        logic       aluSrcB;
        logic [1:0] aluOp;
        logic [2:0] immType;
        logic       regWe;
        logic [1:0] wbSel;
        logic       retire;
        logic       illegal;
    } ctrl_t;

    logic  clk;
    logic  rst;
    int    assertCount;
    int    failCount;
    ctrl_t exp;

    multicycle_ctrl_if busIf ();

    multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctrl_t observed();
        ctrl_t o;
        o.state   = busIf.state;
        o.memReq  = busIf.mem_req;
        o.memWe   = busIf.mem_we;
        o.addrSel = busIf.addr_sel;
        o.irWe    = busIf.ir_we;
        o.pcWe    = busIf.pc_we;
        o.pcSel   = busIf.pc_sel;
        o.aluSrcB = busIf.alu_src_b;
        o.aluOp   = busIf.alu_op;
        o.immType = busIf.imm_type;
        o.regWe   = busIf.reg_we;
        o.wbSel   = busIf.wb_sel;
        o.retire  = busIf.retire;
        o.illegal = busIf.illegal;
        return o;
    endfunction

    // Expected FETCH-cycle outputs; irWe follows the memory handshake.
    function automatic ctrl_t fetchExp(input logic ready);
        ctrl_t e;
        e         = '0;
        e.memReq  = 1'b1;
        e.immType = 3'd4;
        e.irWe    = ready;
        return e;
    endfunction

    // Expected outputs with only state and immediate type set.
    function automatic ctrl_t baseExp(input logic [2:0] st, input logic [2:0] imm);
        ctrl_t e;
        e         = '0;
        e.state   = st;
        e.immType = imm;
        return e;
    endfunction

    task automatic applyStimulus(input logic ready, input logic taken, input logic [31:0] ins);
        busIf.mem_ready    = ready;
        busIf.branch_taken = taken;
        busIf.instr        = ins;
        #1;
    endtask

    task automatic checkOutput(input string tag, input ctrl_t e);
        ctrl_t o;
        o = observed();
        assertCount++;
        assert (o === e) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst         = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
        step();
        step();
        checkOutput("reset_outputs", '0);

        // addi x1,x0,5 with the memory always ready: states 0,1,2,4
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h00500093);
        checkOutput("addi_fetch", fetchExp(1'b1));
        step();
        checkOutput("addi_decode", baseExp(3'd1, 3'd0));
        step();
        exp = baseExp(3'd2, 3'd0); exp.aluOp = 2'd1; exp.aluSrcB = 1'b1;
        checkOutput("addi_exec", exp);
        step();
        exp = baseExp(3'd4, 3'd0); exp.regWe = 1'b1; exp.pcWe = 1'b1; exp.retire = 1'b1;
        checkOutput("addi_wb", exp);
        step();

        // lw x2,0(x1) with two wait cycles in MEM: 7 cycles total
        applyStimulus(1'b1, 1'b0, 32'h0000A103);
        checkOutput("lw_fetch", fetchExp(1'b1));
        step();
        checkOutput("lw_decode", baseExp(3'd1, 3'd0));
        step();
        exp = baseExp(3'd2, 3'd0); exp.aluSrcB = 1'b1;
        checkOutput("lw_exec", exp);
        step();
        exp = baseExp(3'd3, 3'd0); exp.memReq = 1'b1; exp.addrSel = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0000A103);
        checkOutput("lw_mem_wait1", exp);
        step();
        checkOutput("lw_mem_wait2", exp);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000A103);
        checkOutput("lw_mem_ready", exp);
        step();
        exp = baseExp(3'd4, 3'd0); exp.regWe = 1'b1; exp.pcWe = 1'b1;
        exp.retire = 1'b1; exp.wbSel = 2'd1;
        checkOutput("lw_wb", exp);
        step();

        // sw x2,4(x1): store retires in the MEM ready cycle
        applyStimulus(1'b1, 1'b0, 32'h0020A223);
        checkOutput("sw_fetch", fetchExp(1'b1));
        step();
        checkOutput("sw_decode", baseExp(3'd1, 3'd1));
        step();
        exp = baseExp(3'd2, 3'd1); exp.aluSrcB = 1'b1;
        checkOutput("sw_exec", exp);
        step();
        exp = baseExp(3'd3, 3'd1); exp.memReq = 1'b1; exp.addrSel = 1'b1;
        exp.memWe = 1'b1; exp.pcWe = 1'b1; exp.retire = 1'b1;
        checkOutput("sw_mem", exp);
        step();

        // beq taken, then not taken
        applyStimulus(1'b1, 1'b1, 32'h00208463);
        checkOutput("beq1_fetch", fetchExp(1'b1));
        step();
        checkOutput("beq1_decode", baseExp(3'd1, 3'd2));
        step();
        exp = baseExp(3'd2, 3'd2); exp.aluOp = 2'd2; exp.pcWe = 1'b1;
        exp.retire = 1'b1; exp.pcSel = 2'd1;
        checkOutput("beq_taken_exec", exp);
        step();
        applyStimulus(1'b1, 1'b0, 32'h00208463);
        checkOutput("beq2_fetch", fetchExp(1'b1));
        step();
        step();
        exp.pcSel = 2'd0;
        checkOutput("beq_not_taken_exec", exp);
        step();

        // add x3,x1,x2: register operand, no immediate
        applyStimulus(1'b1, 1'b0, 32'h002081B3);
        step();
        checkOutput("add_decode", baseExp(3'd1, 3'd4));
        step();
        exp = baseExp(3'd2, 3'd4); exp.aluOp = 2'd1;
        checkOutput("add_exec", exp);
        step();
        exp = baseExp(3'd4, 3'd4); exp.regWe = 1'b1; exp.pcWe = 1'b1; exp.retire = 1'b1;
        checkOutput("add_wb", exp);
        step();

        // jal x1,8
        applyStimulus(1'b1, 1'b0, 32'h008000EF);
        step();
        checkOutput("jal_decode", baseExp(3'd1, 3'd3));
        step();
        checkOutput("jal_exec", baseExp(3'd2, 3'd3));
        step();
        exp = baseExp(3'd4, 3'd3); exp.regWe = 1'b1; exp.pcWe = 1'b1;
        exp.retire = 1'b1; exp.wbSel = 2'd2; exp.pcSel = 2'd1;
        checkOutput("jal_wb", exp);
        step();

        // jalr x0,0(x1)
        applyStimulus(1'b1, 1'b0, 32'h00008067);
        step();
        step();
        checkOutput("jalr_exec", baseExp(3'd2, 3'd0));
        step();
        exp = baseExp(3'd4, 3'd0); exp.regWe = 1'b1; exp.pcWe = 1'b1;
        exp.retire = 1'b1; exp.wbSel = 2'd2; exp.pcSel = 2'd2;
        checkOutput("jalr_wb", exp);
        step();

        // reset during a fetch wait
        applyStimulus(1'b0, 1'b0, 32'h00500093);
        checkOutput("fetch_wait", fetchExp(1'b0));
        step();
        checkOutput("fetch_wait_hold", fetchExp(1'b0));
        rst = 1'b1;
        step();
        checkOutput("reset_mid_fetch", '0);
        rst = 1'b0;
        #1;
        checkOutput("fetch_after_reset", fetchExp(1'b0));
        step();
        checkOutput("fetch_after_reset_hold", fetchExp(1'b0));

        // unsupported opcode 0x7F
        applyStimulus(1'b1, 1'b0, 32'h0000007F);
        step();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        checkOutput("illegal_decode", baseExp(3'd1, 3'd4));
        step();
        exp = '0; exp.state = 3'd5; exp.illegal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("halt_hold_%0d", i), exp);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checkOutput("halt_exit_reset", fetchExp(1'b1));
`else
        exp = baseExp(3'd1, 3'd4); exp.pcWe = 1'b1; exp.retire = 1'b1;
        checkOutput("illegal_nop_decode", exp);
        step();
        checkOutput("illegal_nop_refetch", fetchExp(1'b1));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencing controller for the RV32I core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, so the shared memory port and ALU are reused across cycles. It drives the select lines for the immediate generator, ALU, PC and register file, and handles a ready handshake with the unified memory port. It decodes the latched instruction register only; it contains no datapath.

## Interface
Parameters:
- none (state encoding fixed; see Operation)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- instr  in  32  instruction register contents; valid from DECODE onward
- mem_ready  in  1  memory port completed the current request this cycle
- branch_taken  in  1  comparator result for current branch; sampled in EXEC
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  request is a store
- addr_sel  out  1  memory address: 0=PC, 1=ALU result
- ir_we  out  1  latch memory read data into the instruction register
- pc_we  out  1  update PC this cycle
- pc_sel  out  2  0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
- alu_src_b  out  1  0=rs2, 1=imm
- alu_op  out  2  0=add, 1=funct3/funct7 decoded, 2=compare
- imm_type  out  3  0=I, 1=S, 2=B, 3=J, 4=none
- reg_we  out  1  register file write enable
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4
- retire  out  1  one-cycle pulse when an instruction completes
- state  out  3  current state for debug
- illegal  out  1  illegal opcode seen (see Configuration)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Outputs are decoded from the state and opcode=instr[6:0]; they are Moore-style, except ir_we, pc_we and retire, which are also gated by mem_ready where noted.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. When mem_ready=1: ir_we=1 and the next state is DECODE. Otherwise the controller stays in FETCH.
- DECODE: imm_type is set from opcode (OP-IMM/LOAD/JALR→I, STORE→S, BRANCH→B, JAL→J, OP→none). Next state is EXEC for the seven supported opcodes.
- EXEC:
  - OP/OP-IMM: alu_op=1, alu_src_b = (opcode==OP-IMM); next state WB.
  - LOAD/STORE: alu_op=0, alu_src_b=1; next state MEM.
  - BRANCH: alu_op=2, pc_we=1, pc_sel = branch_taken ? 1 : 0, retire=1; next state FETCH.
  - JAL/JALR: next state WB.
- MEM: mem_req=1, addr_sel=1, mem_we = (opcode==STORE). The controller holds here until mem_ready.
  - LOAD: next state WB.
  - STORE: pc_we=1, pc_sel=0 and retire=1 in the mem_ready cycle; next state FETCH.
- WB: reg_we=1 and pc_we=1 (with retire=1); next state FETCH.
  - ALU ops: wb_sel=0, pc_sel=0.
  - LOAD: wb_sel=1, pc_sel=0.
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2.
  - The datapath uses the old PC for both the link value and the target in this cycle.
- imm_type holds its DECODE value through EXEC, MEM and WB, and is 4 in FETCH.
- Unlisted outputs are 0 in every state.

## Timing
- Reset: while rst=1, every output is 0 and state=0. The controller enters FETCH on the first clk edge after rst falls, and mem_req=1 in that cycle.
- Reset mid-operation, including during a pending memory request: state returns to FETCH at the next edge and no retire is issued. The memory port must tolerate mem_req being withdrawn.
- Latency with mem_ready=1 on first asserted cycle:
  - branch: 3 cycles
  - OP/OP-IMM, store, JAL, JALR: 4 cycles
  - load: 5 cycles
  - each wait cycle adds 1.
- mem_ready is ignored when mem_req=0. mem_req, mem_we and addr_sel stay stable until mem_ready.
- PC is written exactly once per retired instruction, in the same cycle as retire.

## Configuration
- MC_CTRL_ILLEGAL_TRAP_EN defined: an unsupported opcode in DECODE moves the controller to HALT. In HALT, illegal=1 and all other outputs are 0, and the controller stays there until rst.
- MC_CTRL_ILLEGAL_TRAP_EN undefined: an unsupported opcode is retired as a NOP in DECODE (pc_we=1, pc_sel=0, retire=1), and the next state is FETCH. illegal is tied 0, and the HALT state is absent.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with mem_ready constantly 1 → states 0,1,2,4. In the WB cycle: reg_we=1, wb_sel=0, pc_we=1, pc_sel=0, retire=1.
- lw x2,0(x1) (0x0000A103) with mem_ready delayed 2 cycles in MEM → total 7 cycles. mem_req=1 and addr_sel=1 for 3 cycles, then WB with wb_sel=1.
- sw x2,4(x1) (0x0020A223) → in the MEM cycle: mem_we=1, imm_type=1, retire=1. No reg_we is asserted.
- beq (0x00208463) with branch_taken=1, then again with 0 → 3 cycles each, pc_sel=1 and 0 respectively. jal x1,8 (0x008000EF) → WB with wb_sel=2, pc_sel=1, imm_type=3.
- rst asserted during a fetch wait → next cycle all outputs 0. After release, state=FETCH and no retire pulse occurs.
- Opcode 0x7F: with MC_CTRL_ILLEGAL_TRAP_EN → illegal=1 and state=5, held for 10 cycles. Without the macro → retire=1 and pc_sel=0 in DECODE.
